// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory access unit: op codes, error codes, FSM states, size helpers.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package mau_pkg;

    // Operation codes as driven on the CPU op port
    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    // Error codes reported alongside done
    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_ADEL = 2'd1;
    localparam logic [1:0] ERR_ADES = 2'd2;
    localparam logic [1:0] ERR_BUS  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    // OP_LBU (4) is the only op with bit 2 set that is a load
    function automatic logic is_store(input logic [2:0] op);
        return op[2] & (op != OP_LBU);
    endfunction

    function automatic size_t op_size(input logic [2:0] op);
        size_t sz;
        case (op)
            OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
            default:              sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a_lo);
        logic bad;
        case (op_size(op))
            SZ_WORD: bad = (a_lo != 2'b00);
            SZ_HALF: bad = a_lo[0];
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// CPU-side and memory-side bundles of the memory access unit.
// Latency: n/a (wiring only).
// Backpressure: CPU side stalls on busy; memory side holds mem_req until mem_ack.
//
// mau_cpu_if : master = CPU memory stage, slave = access unit.
//   start/op/PC/A/Din in, busy/done/rdata/err out (as seen by the unit).
// mau_mem_if : master = access unit, slave = data memory.
//   mem_req/we/addr/be/wdata out, mem_ack/mem_rdata in (as seen by the unit).
interface mau_cpu_if #(parameter int unsigned ADDR_W = 32);
    logic              start;
    logic [2:0]        op;
    logic [31:0]       PC;
    logic [ADDR_W-1:0] A;
    logic [31:0]       Din;
    logic              busy;
    logic              done;
    logic [31:0]       rdata;
    logic [1:0]        err;

    modport master (output start, op, PC, A, Din, input busy, done, rdata, err);
    modport slave  (input start, op, PC, A, Din, output busy, done, rdata, err);
endinterface

interface mau_mem_if #(parameter int unsigned ADDR_W = 32);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata, input mem_ack, mem_rdata);
    modport slave  (input mem_req, mem_we, mem_addr, mem_be, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_access_unit_lane.sv
// Byte-lane logic: byte enables and replicated store data for a new op, load lane extraction/extension.
// Latency: purely combinational.
// Backpressure: none; the parent FSM decides when outputs are sampled.
//
// Ports: st_op_i/st_addr_lo_i/din_i -> be_o/wdata_o (op being accepted);
//        ld_op_i/ld_addr_lo_i/rdata_i -> ld_data_o (op in flight, word from memory).
module mau_lane
    import mau_pkg::*;
(
    input  logic [2:0]  st_op_i,
    input  logic [1:0]  st_addr_lo_i,
    input  logic [31:0] din_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    input  logic [2:0]  ld_op_i,
    input  logic [1:0]  ld_addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = din_i;
        case (op_size(st_op_i))
            SZ_BYTE: begin
                be_o    = 4'b0001 << st_addr_lo_i;
                wdata_o = {4{din_i[7:0]}};
            end
            SZ_HALF: begin
                be_o    = st_addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{din_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        byte_v    = rdata_i[{ld_addr_lo_i, 3'b000} +: 8];
        half_v    = ld_addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        ld_data_o = rdata_i;
        case (ld_op_i)
            OP_LB:   ld_data_o = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  ld_data_o = {24'd0, byte_v};
            OP_LH:   ld_data_o = {{16{half_v[15]}}, half_v};
            OP_LHU:  ld_data_o = {16'd0, half_v};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator between CPU memory stage and word-addressed data memory, with alignment and bus-timeout checks.
// Latency: start->done 2 cycles with zero-wait memory (+1 per wait state), 1 cycle for misaligned ops.
// Backpressure: busy stalls the CPU until done; mem_req holds until mem_ack or TIMEOUT wait cycles.
//
// Ports: Clk, Reset (async, active-high); cpu (mau_cpu_if.slave); mem (mau_mem_if.master).
// Optional: define MEM_TRACE_EN to print each store (PC, word address, merged word) on its ack.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic       Clk,
    input  logic       Reset,
    mau_cpu_if.slave   cpu,
    mau_mem_if.master  mem
);

    localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

    state_t            state_q;
    logic [7:0]        wait_q;
    logic [2:0]        op_q;
    logic [31:0]       pc_q;
    logic [1:0]        a_lo_q;
    logic              busy_q;
    logic              done_q;
    logic [31:0]       rdata_q;
    logic [1:0]        err_q;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-3:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;

    logic [3:0]        be_d;
    logic [31:0]       wdata_d;
    logic [31:0]       ld_data_d;

    // be/wdata are computed from the op being accepted so they can be registered at start;
    // load extraction uses the latched op/lane against the live memory word.
    mau_lane u_lane (
        .st_op_i      (cpu.op),
        .st_addr_lo_i (cpu.A[1:0]),
        .din_i        (cpu.Din),
        .be_o         (be_d),
        .wdata_o      (wdata_d),
        .ld_op_i      (op_q),
        .ld_addr_lo_i (a_lo_q),
        .rdata_i      (mem.mem_rdata),
        .ld_data_o    (ld_data_d)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            wait_q  <= 8'd0;
            op_q    <= OP_LW;
            pc_q    <= 32'd0;
            a_lo_q  <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= ERR_NONE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cpu.start) begin
                        op_q   <= cpu.op;
                        pc_q   <= cpu.PC;
                        a_lo_q <= cpu.A[1:0];
                        busy_q <= 1'b1;
                        if (misaligned(cpu.op, cpu.A[1:0])) begin
                            // Never reaches the bus: report straight away
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            rdata_q <= 32'd0;
                            err_q   <= is_store(cpu.op) ? ERR_ADES : ERR_ADEL;
                        end else begin
                            state_q <= ST_REQ;
                            req_q   <= 1'b1;
                            we_q    <= is_store(cpu.op);
                            addr_q  <= cpu.A[ADDR_W-1:2];
                            be_q    <= be_d;
                            wdata_q <= wdata_d;
                            wait_q  <= 8'd0;
                        end
                    end
                end
                ST_REQ: begin
                    // Ack wins over timeout in the same cycle
                    if (mem.mem_ack) begin
                        state_q <= ST_DONE;
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= ERR_NONE;
                        rdata_q <= we_q ? 32'd0 : ld_data_d;
                    end else if (wait_q == TIMEOUT_M1) begin
                        state_q <= ST_DONE;
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= ERR_BUS;
                        rdata_q <= 32'd0;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cpu.busy      = busy_q;
    assign cpu.done      = done_q;
    assign cpu.rdata     = rdata_q;
    assign cpu.err       = err_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = wdata_q;

`ifdef MEM_TRACE_EN
    // Memory returns the pre-write word on store acks; fill non-enabled lanes from it
    logic [31:0] trace_merged;
    always_comb begin
        trace_merged = mem.mem_rdata;
        for (int i = 0; i < 4; i++) begin
            if (be_q[i]) trace_merged[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset && state_q == ST_REQ && mem.mem_ack && we_q)
            $display("@%h: *%h <= %h", pc_q, {addr_q, 2'b00}, trace_merged);
    end
`else
    // PC is only consumed by the store trace
    logic unused_trace;
    assign unused_trace = ^pc_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    import mau_pkg::*;

    logic Clk;
    logic Reset;

    mau_cpu_if #(.ADDR_W(32)) cpu ();
    mau_mem_if #(.ADDR_W(32)) mem ();

    mem_access_unit #(.TIMEOUT(4), .ADDR_W(32)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .cpu   (cpu),
        .mem   (mem)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
        int          cycles;
        bit          chk_rdata;
    } exp_t;
    exp_t sb[$];

    // Memory responder controls and observations
    int          mem_wait   = 0;      // wait cycles before ack; negative = never ack
    logic [31:0] mem_word   = 32'd0;
    bit          stray_ack  = 1'b0;
    int          req_cnt    = 0;
    int          req_cycles = 0;
    int          req_rises  = 0;
    logic [3:0]  cap_be;
    logic [29:0] cap_addr;
    logic [31:0] cap_wdata;
    logic        cap_we;
    bit          stable;

    initial begin
        mem.mem_ack   = 1'b0;
        mem.mem_rdata = 32'd0;
        forever begin
            @(posedge Clk);
            #1;
            if (mem.mem_req) begin
                if (req_cnt == 0) begin
                    cap_be    = mem.mem_be;
                    cap_addr  = mem.mem_addr;
                    cap_wdata = mem.mem_wdata;
                    cap_we    = mem.mem_we;
                    stable    = 1'b1;
                    req_rises++;
                end else if (mem.mem_be !== cap_be || mem.mem_addr !== cap_addr ||
                             mem.mem_wdata !== cap_wdata || mem.mem_we !== cap_we) begin
                    stable = 1'b0;
                end
                req_cycles++;
                mem.mem_ack   = (mem_wait >= 0) && (req_cnt == mem_wait);
                mem.mem_rdata = mem.mem_ack ? mem_word : 32'hDEAD_BEEF;
                req_cnt++;
            end else begin
                req_cnt       = 0;
                mem.mem_ack   = stray_ack;
                mem.mem_rdata = 32'h5555_AAAA;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    // Issue one op, wait (bounded) for done, compare against the scoreboard entry.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] din, input int wait_n, input logic [31:0] word,
                          input logic [31:0] exp_rdata, input logic [1:0] exp_err,
                          input int exp_cycles, input int exp_req, input bit hold_start);
        exp_t e;
        exp_t got;
        int n;
        logic busy_at_done;
        e.rdata = exp_rdata; e.err = exp_err; e.cycles = exp_cycles;
        e.chk_rdata = !is_store(op);
        sb.push_back(e);
        mem_wait   = wait_n;
        mem_word   = word;
        req_cycles = 0;
        cpu.op     = op;
        cpu.A      = a;
        cpu.Din    = din;
        cpu.PC     = 32'h0000_1000 + a;
        cpu.start  = 1'b1;
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (!hold_start) cpu.start = 1'b0;
            if (cpu.done) break;
        end
        got.rdata  = cpu.rdata;
        got.err    = cpu.err;
        got.cycles = n;
        busy_at_done = cpu.busy;
        if (hold_start) begin
            tick();          // start still high across the done cycle
            cpu.start = 1'b0;
        end
        e = sb.pop_front();
        check({tag, "_cycles"}, got.cycles, e.cycles);
        check({tag, "_err"}, {30'd0, got.err}, {30'd0, e.err});
        if (e.chk_rdata) check({tag, "_rdata"}, got.rdata, e.rdata);
        check({tag, "_busy_at_done"}, {31'd0, busy_at_done}, 32'd1);
        check({tag, "_req_cycles"}, req_cycles, exp_req);
    endtask

    initial begin
        Reset     = 1'b1;
        cpu.start = 1'b0;
        cpu.op    = OP_LW;
        cpu.A     = 32'd0;
        cpu.Din   = 32'd0;
        cpu.PC    = 32'd0;
        tick();
        tick();

        // Reset state
        check("rst_busy",  {31'd0, cpu.busy}, 32'd0);
        check("rst_done",  {31'd0, cpu.done}, 32'd0);
        check("rst_req",   {31'd0, mem.mem_req}, 32'd0);
        check("rst_we",    {31'd0, mem.mem_we}, 32'd0);
        check("rst_be",    {28'd0, mem.mem_be}, 32'd0);
        check("rst_addr",  {2'd0, mem.mem_addr}, 32'd0);
        check("rst_wdata", mem.mem_wdata, 32'd0);
        check("rst_rdata", cpu.rdata, 32'd0);
        check("rst_err",   {30'd0, cpu.err}, 32'd0);
        Reset = 1'b0;
        tick();

        // LB, top byte lane, sign-extended, zero wait
        run_op("lb3", OP_LB, 32'h0000_0003, 32'd0, 0, 32'h80AA_BBCC,
               32'hFFFF_FF80, ERR_NONE, 2, 1, 1'b0);
        check("lb3_be", {28'd0, cap_be}, 32'h8);
        check("lb3_we", {31'd0, cap_we}, 32'd0);
        tick();

        // SH upper half with three wait states
        run_op("sh12", OP_SH, 32'h0000_0012, 32'h1234_5678, 3, 32'h0,
               32'd0, ERR_NONE, 5, 4, 1'b0);
        check("sh12_addr",   {2'd0, cap_addr}, 32'h4);
        check("sh12_be",     {28'd0, cap_be}, 32'hC);
        check("sh12_wdata",  cap_wdata, 32'h5678_5678);
        check("sh12_we",     {31'd0, cap_we}, 32'd1);
        check("sh12_stable", {31'd0, stable}, 32'd1);
        tick();

        // Misaligned LW: no bus cycle
        run_op("lw6", OP_LW, 32'h0000_0006, 32'd0, 0, 32'hFFFF_FFFF,
               32'd0, ERR_ADEL, 1, 0, 1'b0);
        tick();

        // Misaligned SW
        run_op("sw5", OP_SW, 32'h0000_0005, 32'h1111_2222, 0, 32'd0,
               32'd0, ERR_ADES, 1, 0, 1'b0);
        tick();

        // LHU with no ack: times out after TIMEOUT=4 request cycles
        run_op("lhu_to", OP_LHU, 32'h0000_0000, 32'd0, -1, 32'd0,
               32'd0, ERR_BUS, 5, 4, 1'b0);
        check("lhu_to_req_low", {31'd0, mem.mem_req}, 32'd0);
        tick();

        // LH upper half, sign-extended, one wait state
        run_op("lh2", OP_LH, 32'h0000_0002, 32'd0, 1, 32'h8001_7FFF,
               32'hFFFF_8001, ERR_NONE, 3, 2, 1'b0);
        check("lh2_be", {28'd0, cap_be}, 32'hC);
        tick();

        // SB lane 1, replicated data
        run_op("sb1", OP_SB, 32'h0000_0041, 32'h0000_00AB, 0, 32'd0,
               32'd0, ERR_NONE, 2, 1, 1'b0);
        check("sb1_be",    {28'd0, cap_be}, 32'h2);
        check("sb1_wdata", cap_wdata, 32'hABAB_ABAB);
        check("sb1_addr",  {2'd0, cap_addr}, 32'h10);
        tick();

        // Ack while idle must not start anything
        stray_ack = 1'b1;
        tick(); tick(); tick();
        check("stray_busy", {31'd0, cpu.busy}, 32'd0);
        check("stray_done", {31'd0, cpu.done}, 32'd0);
        check("stray_req",  {31'd0, mem.mem_req}, 32'd0);
        stray_ack = 1'b0;
        tick();

        // Reset mid-REQ of an SW: outputs drop without a clock edge
        mem_wait  = -1;
        cpu.op    = OP_SW;
        cpu.A     = 32'h0000_0020;
        cpu.Din   = 32'hCAFE_BABE;
        cpu.start = 1'b1;
        tick();
        cpu.start = 1'b0;
        tick();
        check("mid_req_up", {31'd0, mem.mem_req}, 32'd1);
        #2;
        Reset = 1'b1;
        #1;
        check("arst_req",  {31'd0, mem.mem_req}, 32'd0);
        check("arst_busy", {31'd0, cpu.busy}, 32'd0);
        check("arst_done", {31'd0, cpu.done}, 32'd0);
        tick();
        tick();
        Reset = 1'b0;
        tick();

        run_op("lbu_after_rst", OP_LBU, 32'h0000_0000, 32'd0, 0, 32'h0000_00F0,
               32'h0000_00F0, ERR_NONE, 2, 1, 1'b0);
        tick();

        // start held high while busy and through the done cycle: exactly one request
        req_rises = 0;
        run_op("hold", OP_LW, 32'h0000_0008, 32'd0, 2, 32'hCAFE_F00D,
               32'hCAFE_F00D, ERR_NONE, 4, 3, 1'b1);
        tick(); tick(); tick(); tick();
        check("hold_rises", req_rises, 1);
        check("hold_idle_busy", {31'd0, cpu.busy}, 32'd0);

        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store initiator between the CPU memory stage and the word-addressed data memory.
- Accepts one byte/half/word load or store per transaction and checks alignment.
- Drives a req/ack memory port with word address, byte enables and replicated store data; sign/zero-extends load data.
- Multi-cycle: stalls the CPU via busy until done pulses; memory may insert any number of wait states up to a timeout.

Parameters:
- TIMEOUT, 255: max cycles in REQ without mem_ack before bus-timeout error; legal 1..255.
- ADDR_W, 32: CPU byte-address width; mem_addr is ADDR_W-2 bits.

Ports:
- Clk  input  1  clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; ignored while busy.
- op  input  3  operation code (mau_pkg encoding).
- PC  input  32  PC of the issuing instruction, latched for trace.
- A  input  ADDR_W  byte address.
- Din  input  32  store data, low bits significant for SB/SH.
- busy  output  1  high from the cycle after an accepted start through the done cycle.
- done  output  1  one-cycle completion pulse.
- rdata  output  32  extended load data; valid on done, held until the next accepted start.
- err  output  2  error code; valid with done, held like rdata.
- mem_req  output  1  memory request.
- mem_we  output  1  1 = store.
- mem_addr  output  ADDR_W-2  word address, A[ADDR_W-1:2].
- mem_be  output  4  byte enables.
- mem_wdata  output  32  replicated store data.
- mem_ack  input  1  memory accepted/completed current request.
- mem_rdata  input  32  full read word, valid with mem_ack.

Behaviour:
- Reset: asynchronous, active-high. Takes effect immediately, including mid-transaction.
  - State IDLE; wait counter 0.
  - busy, done, mem_req, mem_we = 0; mem_be = 0; mem_addr, mem_wdata, rdata = 0; err = ERR_NONE.
  - An in-flight request is abandoned and mem_req drops immediately.
- All outputs are registered.
- FSM states: IDLE, REQ, DONE.
- IDLE, start=1, address aligned:
  - Latch op, PC, A, Din.
  - Next cycle: state REQ, mem_req=1, busy=1.
  - mem_addr, mem_be, mem_we and mem_wdata are stable for the whole of REQ.
- IDLE, start=1, misaligned (LW/SW with A[1:0]!=0; LH/LHU/SH with A[0]=1):
  - No memory request is issued.
  - Next cycle: state DONE, err = ERR_ADEL for loads or ERR_ADES for stores, rdata = 0.
- REQ:
  - mem_ack is sampled each cycle, including the first cycle of mem_req (zero-wait accepted).
  - On ack: capture and extend mem_rdata (loads), err = ERR_NONE, mem_req=0 next cycle, state DONE.
  - No ack: wait counter +1. When counter reaches TIMEOUT: mem_req=0, err = ERR_BUS, rdata = 0, state DONE.
  - Counter clears on entry to REQ.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE with busy=0. A start in the DONE cycle is ignored.
- mem_ack while mem_req=0 is ignored.
- Byte enables, loads and stores alike:
  - byte ops: 4'b0001 << A[1:0].
  - half ops: A[1] ? 4'b1100 : 4'b0011.
  - word ops: 4'b1111.
- Store data:
  - SB: {4{Din[7:0]}}.
  - SH: {2{Din[15:0]}}.
  - SW: Din.
- Load extraction: the lane is selected by A[1:0] (byte) or A[1] (half).
  - LB, LH: sign-extend.
  - LBU, LHU: zero-extend.
  - LW: unchanged.
- Latency, aligned op with zero-wait memory: start at cycle 0, mem_req at cycle 1, ack at cycle 1, done at cycle 2. Each memory wait cycle adds 1.
- Misaligned latency: done at cycle 1.

Optional Feature:
- Macro MEM_TRACE_EN.
- Defined: on each store ack, $display("@%h: *%h <= %h", PC_latched, {A[31:2],2'b00}, merged), where merged is mem_wdata with non-enabled bytes taken from mem_rdata.
  - With the macro defined, memory returns the pre-write word on store acks.
- Undefined: no display; mem_rdata is ignored on stores.
- Port list and timing are identical either way.

Decomposition:
- Package mau_pkg holds:
  - op codes: OP_LW=0, OP_LH=1, OP_LHU=2, OP_LB=3, OP_LBU=4, OP_SW=5, OP_SH=6, OP_SB=7.
  - is_store = op[2]&(op!=4).
  - err codes: ERR_NONE=0, ERR_ADEL=1, ERR_ADES=2, ERR_BUS=3.
  - FSM state encoding.
- Sub-module mau_lane: combinational be/wdata generation and load extraction/extension. The FSM stays in the top module.

Test Plan:
- LB at A=0x0000_0003, memory returns 0x80AA_BBCC with zero wait -> mem_be=4'b1000, rdata=0xFFFF_FF80, done at cycle 2, err=0.
- SH at A=0x0000_0012, Din=0x1234_5678, ack after 3 wait cycles -> mem_addr=0x4, mem_be=4'b1100, mem_wdata=0x5678_5678, mem_we=1, done 3 cycles after the zero-wait case.
- LW at A=0x0000_0006 -> no mem_req, done at cycle 1, err=1 (ERR_ADEL), rdata=0.
- LHU at A=0x0000_0000, TIMEOUT=4, mem_ack never asserted -> mem_req high 4 cycles then low, done with err=3.
- Reset asserted mid-REQ of an SW -> mem_req, busy and done go low immediately without waiting for Clk; a new LBU after release with ack 0x0000_00F0 -> rdata=0xF0.
- start asserted on the done cycle and while busy -> ignored; no second mem_req.
